wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Program controller for the washing machine. After billing confirms payment, it runs the selected program through fill, wash, rinse and spin phases using per-phase second countdowns.
- Drives the valve, motor, drain and door-lock outputs.
- Exports phase, remaining time (binary and 2-digit BCD for the 4-digit display scanner) and a one-cycle done pulse back to billing.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick (bench uses 4)
FILL_S, 3, fill duration in s (1..99; 0 = skip phase)
WASH_S_SMALL, 5, wash duration in s, mode 01
WASH_S_MED, 8, wash duration in s, mode 10
WASH_S_LARGE, 12, wash duration in s, mode 11
RINSE_S, 4, rinse duration in s
SPIN_S, 6, spin duration in s
DRAIN_S, 2, abort drain duration in s

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse (debounced upstream); begins program; honoured only in IDLE
mode  in  2  00 spin-only, 01 small, 10 medium, 11 large; sampled on accepted start
pause  in  1  one-cycle pulse; toggles pause in FILL/WASH/RINSE/SPIN
abort  in  1  one-cycle pulse; stops the program via DRAIN
phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DRAIN, 6 DONE
paused  out  1  pause active
remain  out  7  seconds left in current phase (binary)
remain_bcd  out  8  remain as {tens, units} BCD
busy  out  1  phase not IDLE and not DONE
door_lock  out  1  equals busy
valve  out  1  water inlet
motor  out  2  00 off, 01 wash speed, 10 spin speed
drain  out  1  drain pump
done  out  1  one-cycle pulse on program end
aborted  out  1  latched when the program ended via abort; cleared on next accepted start

Behaviour:
- Reset (async, rst=0): phase=IDLE, prescaler=0, mode register=00. All outputs are 0: paused, remain, remain_bcd, busy, door_lock, valve, motor, drain, done, aborted.
- Registered outputs: all outputs except remain_bcd are registered. remain_bcd is a combinational conversion of remain (remain <= 99).
- Start: start in IDLE at cycle n gives the first program phase with its remain loaded at cycle n+1.
  - Modes 01/10/11 begin at FILL.
  - Mode 00 begins at SPIN.
  - Phases with a 0 duration are skipped in the same cycle, recursively.
  - start outside IDLE is ignored.
- Phase order: FILL -> WASH (duration by latched mode) -> RINSE -> SPIN -> DONE.
- Tick: the prescaler counts 0..TICK_DIV-1 only while busy and not paused. It clears on every phase entry. The tick fires when the count reaches TICK_DIV-1.
- Countdown: on tick, remain decrements. If remain is 1 on a tick, the block transitions that cycle: the next phase is entered, its remain is loaded and the prescaler is cleared.
- DONE: lasts exactly one cycle with done=1, then IDLE with remain=0.
- Pause: a pause pulse toggles paused in FILL/WASH/RINSE/SPIN.
  - While paused: prescaler and remain are frozen; valve=0, motor=00, drain=0; door_lock stays 1.
  - Resume continues from the frozen prescaler value.
  - pause is ignored in IDLE, DRAIN and DONE.
- Abort: abort in any busy phase (paused or not) enters DRAIN next cycle.
  - On entry: remain=DRAIN_S, paused cleared, aborted set.
  - DRAIN runs to DONE normally.
  - abort in IDLE, DRAIN or DONE is ignored.
- Output decode (when not paused):
  - valve=1 in FILL and RINSE.
  - motor=01 in WASH and RINSE; motor=10 in SPIN.
  - drain=1 in SPIN and DRAIN.
  - All three are 0 elsewhere.
- Simultaneous events, priority: abort > pause > tick.
  - pause and tick in the same cycle: pause wins and the tick is discarded; remain is unchanged.
- Reset mid-operation: returns immediately to IDLE with all outputs 0. No done pulse is generated.
- The mode input changing mid-program has no effect.

Test Plan:
- TICK_DIV=4, mode=01, start at cycle 0 -> phase=1, remain=3, valve=1, door_lock=1 at cycle 1. Then WASH remain=5 at cycle 13, RINSE remain=4 at cycle 33, SPIN remain=6 at cycle 49 (motor=10, drain=1), DONE with done=1 at cycle 73, IDLE at cycle 74.
- mode=00 start -> phase=4 (SPIN), remain=6, remain_bcd=0x06 next cycle. done pulse after 24 cycles; aborted=0.
- mode=11 -> WASH loads remain=12, remain_bcd=0x12; outputs show 0x11 then 0x10 after successive ticks.
- Pause pulse in WASH at remain=3 -> paused=1, motor=00, door_lock=1, remain held 3 for 50 cycles. Second pause pulse -> motor=01, countdown resumes with the same prescaler value.
- Abort during paused RINSE -> next cycle phase=5, remain=2, paused=0, drain=1, aborted=1. DONE after 8 cycles. A new start clears aborted.
- Start pulse during WASH -> ignored. pause and tick in the same cycle -> remain unchanged, paused=1. rst low mid-SPIN -> phase=0, all outputs 0, no done pulse.

Source files
------------

// File: rtl/wash_sequencer_if.sv
// Control and status bundle between billing/front panel and the wash sequencer.
interface wash_sequencer_if;
  // start, pause and abort are single-cycle strobes with no ready; the sequencer
  // samples them on every rising clk edge and silently drops any that are not
  // legal in the current phase.
  logic       start;
  logic [1:0] mode;
  logic       pause;
  logic       abort;
  logic [2:0] phase;
  logic       paused;
  logic [6:0] remain;
  logic [7:0] remain_bcd;
  logic       busy;
  logic       door_lock;
  logic       valve;
  logic [1:0] motor;
  logic       drain;
  logic       done;
  logic       aborted;

  modport master (
    output start, mode, pause, abort,
    input  phase, paused, remain, remain_bcd, busy, door_lock, valve, motor, drain, done, aborted
  );

  modport slave (
    input  start, mode, pause, abort,
    output phase, paused, remain, remain_bcd, busy, door_lock, valve, motor, drain, done, aborted
  );
endinterface

// File: rtl/wash_sequencer.sv
// Washing machine program sequencer: fill, wash, rinse and spin phases timed by
// per-phase second countdowns, with pause, abort-to-drain and a done pulse.
module wash_sequencer #(
  parameter int TICK_DIV     = 100000000,
  parameter int FILL_S       = 3,
  parameter int WASH_S_SMALL = 5,
  parameter int WASH_S_MED   = 8,
  parameter int WASH_S_LARGE = 12,
  parameter int RINSE_S      = 4,
  parameter int SPIN_S       = 6,
  parameter int DRAIN_S      = 2
) (
  input  logic             clk,
  input  logic             rst,
  wash_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    mode_r, mode_n;
  logic [6:0]    remain_n;
  logic          paused_n, aborted_n, done_n;
  logic          busy_n, act_n, valve_n, drain_n;
  logic [1:0]    motor_n;
  logic          runnable, run, tick;

  function automatic logic [6:0] dur(input state_t s, input logic [1:0] m);
    case (s)
      FILL:  dur = 7'(FILL_S);
      WASH:  case (m)
               2'b10:   dur = 7'(WASH_S_MED);
               2'b11:   dur = 7'(WASH_S_LARGE);
               default: dur = 7'(WASH_S_SMALL);
             endcase
      RINSE: dur = 7'(RINSE_S);
      SPIN:  dur = 7'(SPIN_S);
      DRAIN: dur = 7'(DRAIN_S);
      default: dur = 7'd0;
    endcase
  endfunction

  // First program phase at or after s with a nonzero duration; DONE if none remain.
  function automatic state_t first_from(input logic [2:0] s, input logic [1:0] m);
    first_from = DONE;
    for (int i = 4; i >= 1; i--) begin
      if (3'(i) >= s && dur(state_t'(3'(i)), m) != 7'd0) first_from = state_t'(3'(i));
    end
  endfunction

  assign runnable = (state == FILL) || (state == WASH) || (state == RINSE) || (state == SPIN);
  assign run      = (runnable || state == DRAIN) && !bus.paused;
  assign tick     = run && (cnt == CNT_MAX);

  always_comb begin
    state_n   = state;
    remain_n  = bus.remain;
    cnt_n     = cnt;
    mode_n    = mode_r;
    paused_n  = bus.paused;
    aborted_n = bus.aborted;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_n    = bus.mode;
          aborted_n = 1'b0;
          state_n   = first_from((bus.mode == 2'b00) ? SPIN : FILL, bus.mode);
        end
      end
      DONE: state_n = IDLE;
      default: begin
        if (bus.abort && runnable) begin
          state_n   = DRAIN;
          paused_n  = 1'b0;
          aborted_n = 1'b1;
        end else if (bus.pause && runnable) begin
          // The prescaler still moves this cycle, but a coinciding tick is lost.
          paused_n = !bus.paused;
          if (run) cnt_n = tick ? '0 : cnt + 1'b1;
        end else if (run) begin
          if (!tick) begin
            cnt_n = cnt + 1'b1;
          end else if (bus.remain > 7'd1) begin
            remain_n = bus.remain - 7'd1;
            cnt_n    = '0;
          end else begin
            state_n = (state == DRAIN) ? DONE : first_from(3'(state) + 3'd1, mode_r);
          end
        end
      end
    endcase
    if (state_n != state) begin
      remain_n = dur(state_n, mode_n);
      cnt_n    = '0;
      done_n   = (state_n == DONE);
    end
    busy_n  = (state_n == FILL) || (state_n == WASH) || (state_n == RINSE) ||
              (state_n == SPIN) || (state_n == DRAIN);
    act_n   = busy_n && !paused_n;
    valve_n = act_n && (state_n == FILL || state_n == RINSE);
    motor_n = {act_n && (state_n == SPIN), act_n && (state_n == WASH || state_n == RINSE)};
    drain_n = act_n && (state_n == SPIN || state_n == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mode_r        <= 2'b00;
      bus.phase     <= 3'd0;
      bus.paused    <= 1'b0;
      bus.remain    <= 7'd0;
      bus.busy      <= 1'b0;
      bus.door_lock <= 1'b0;
      bus.valve     <= 1'b0;
      bus.motor     <= 2'b00;
      bus.drain     <= 1'b0;
      bus.done      <= 1'b0;
      bus.aborted   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      mode_r        <= mode_n;
      bus.phase     <= state_n;
      bus.paused    <= paused_n;
      bus.remain    <= remain_n;
      bus.busy      <= busy_n;
      bus.door_lock <= busy_n;
      bus.valve     <= valve_n;
      bus.motor     <= motor_n;
      bus.drain     <= drain_n;
      bus.done      <= done_n;
      bus.aborted   <= aborted_n;
    end
  end

  assign bus.remain_bcd = {4'(bus.remain / 7'd10), 4'(bus.remain % 7'd10)};
endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed program walk-throughs plus random stimulus,
// every cycle compared against a phase-plan reference model.
module tb_wash_sequencer;
  localparam int TICK = 4;
  localparam int W    = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wash_sequencer_if bus();

  wash_sequencer #(.TICK_DIV(TICK)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: a queue of phases still to run, plus the live countdown.
  int m_phase, m_remain, m_sub, m_mode;
  bit m_paused, m_aborted, m_done;
  int plan[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dur_of(input int ph, input int md);
    case (ph)
      1: return 3;
      2: return (md == 3) ? 12 : (md == 2) ? 8 : 5;
      3: return 4;
      4: return 6;
      5: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_outputs();
    bit busy = (m_phase >= 1) && (m_phase <= 5);
    bit act  = busy && !m_paused;
    return {3'(m_phase), m_paused, 7'(m_remain), 4'(m_remain / 10), 4'(m_remain % 10),
            busy, busy, act && (m_phase == 1 || m_phase == 3),
            act && (m_phase == 4), act && (m_phase == 2 || m_phase == 3),
            act && (m_phase == 4 || m_phase == 5), m_done, m_aborted};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_remain = 0; m_sub = 0; m_mode = 0;
    m_paused = 0; m_aborted = 0; m_done = 0;
    plan.delete();
    exp_q.delete();
  endtask

  task automatic model_advance();
    m_sub = 0;
    if (plan.size() == 0) begin
      m_phase = 6; m_remain = 0; m_done = 1;
    end else begin
      m_phase  = plan.pop_front();
      m_remain = dur_of(m_phase, m_mode);
    end
  endtask

  task automatic model_step(input bit st, input int md, input bit pz, input bit ab);
    bit run = (m_phase >= 1) && (m_phase <= 5) && !m_paused;
    bit ctl = (m_phase >= 1) && (m_phase <= 4);
    m_done = 0;
    if (m_phase == 0) begin
      if (st) begin
        m_mode = md; m_aborted = 0; plan.delete();
        for (int ph = (md == 0) ? 4 : 1; ph <= 4; ph++)
          if (dur_of(ph, md) != 0) plan.push_back(ph);
        model_advance();
      end
    end else if (m_phase == 6) begin
      m_phase = 0; m_remain = 0;
    end else if (ab && ctl) begin
      plan.delete(); plan.push_back(5);
      m_paused = 0; m_aborted = 1;
      model_advance();
    end else if (pz && ctl) begin
      m_paused = !m_paused;
      if (run) m_sub = (m_sub + 1) % TICK;
    end else if (run) begin
      m_sub = (m_sub + 1) % TICK;
      if (m_sub == 0) begin
        m_remain--;
        if (m_remain == 0) model_advance();
      end
    end
  endtask

  task automatic compare(input string where);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({where, ".queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({where, ".phase"},      bus.phase,      e[26:24]);
    check({where, ".paused"},     bus.paused,     e[23]);
    check({where, ".remain"},     bus.remain,     e[22:16]);
    check({where, ".remain_bcd"}, bus.remain_bcd, e[15:8]);
    check({where, ".busy"},       bus.busy,       e[7]);
    check({where, ".door_lock"},  bus.door_lock,  e[6]);
    check({where, ".valve"},      bus.valve,      e[5]);
    check({where, ".motor"},      bus.motor,      e[4:3]);
    check({where, ".drain"},      bus.drain,      e[2]);
    check({where, ".done"},       bus.done,       e[1]);
    check({where, ".aborted"},    bus.aborted,    e[0]);
  endtask

  // Drive one cycle of inputs, advance the model on the same edge, compare #1 later.
  task automatic step(input bit s, input logic [1:0] md, input bit p, input bit a, input string where);
    bus.start = s; bus.mode = md; bus.pause = p; bus.abort = a;
    @(posedge clk);
    model_step(s, int'(md), p, a);
    exp_q.push_back(model_outputs());
    #1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    compare(where);
  endtask

  task automatic idle(input int n, input string where);
    repeat (n) step(1'b0, bus.mode, 1'b0, 1'b0, where);
  endtask

  task automatic run_until(input int ph, input int max, input string where);
    int g = 0;
    while (int'(bus.phase) != ph && g < max) begin
      idle(1, where);
      g++;
    end
    check({where, ".reach"}, bus.phase, ph);
  endtask

  task automatic apply_reset(input string where);
    rst = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_outputs());
    compare(where);
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(model_outputs());
    compare(where);
    rst = 1'b1;
  endtask

  initial begin
    int r;
    bus.start = 1'b0; bus.mode = 2'b00; bus.pause = 1'b0; bus.abort = 1'b0;
    #2;
    apply_reset("reset");

    // Small program, phase boundaries at fixed cycle offsets.
    step(1'b1, 2'b01, 1'b0, 1'b0, "t1");
    check("t1.fill_phase", bus.phase, 1);
    check("t1.fill_remain", bus.remain, 3);
    check("t1.fill_valve", bus.valve, 1);
    check("t1.fill_lock", bus.door_lock, 1);
    for (int k = 2; k <= 74; k++) begin
      idle(1, "t1");
      if (k == 13) begin check("t1.wash_phase", bus.phase, 2); check("t1.wash_remain", bus.remain, 5); end
      if (k == 33) begin check("t1.rinse_phase", bus.phase, 3); check("t1.rinse_remain", bus.remain, 4); end
      if (k == 49) begin check("t1.spin_motor", bus.motor, 2); check("t1.spin_drain", bus.drain, 1); end
      if (k == 73) begin check("t1.done", bus.done, 1); check("t1.done_phase", bus.phase, 6); end
      if (k == 74) check("t1.idle_phase", bus.phase, 0);
    end

    // Spin-only program.
    step(1'b1, 2'b00, 1'b0, 1'b0, "t2");
    check("t2.phase", bus.phase, 4);
    check("t2.remain_bcd", bus.remain_bcd, 8'h06);
    idle(23, "t2");
    idle(1, "t2");
    check("t2.done", bus.done, 1);
    check("t2.aborted", bus.aborted, 0);
    idle(1, "t2");

    // Large program: BCD across two digits.
    step(1'b1, 2'b11, 1'b0, 1'b0, "t3");
    run_until(2, 40, "t3");
    check("t3.bcd12", bus.remain_bcd, 8'h12);
    idle(TICK, "t3");
    check("t3.bcd11", bus.remain_bcd, 8'h11);
    idle(TICK, "t3");
    check("t3.bcd10", bus.remain_bcd, 8'h10);
    step(1'b0, 2'b11, 1'b0, 1'b1, "t3");
    run_until(0, 40, "t3");

    // Pause hold in WASH, start ignored, abort from paused RINSE.
    step(1'b1, 2'b01, 1'b0, 1'b0, "t4");
    r = 0;
    while (!(bus.phase == 3'd2 && bus.remain == 7'd3) && r < 200) begin idle(1, "t4"); r++; end
    check("t4.reach_wash3", bus.remain, 3);
    step(1'b0, 2'b01, 1'b1, 1'b0, "t4");
    check("t4.paused", bus.paused, 1);
    check("t4.motor_off", bus.motor, 0);
    check("t4.lock", bus.door_lock, 1);
    idle(50, "t4");
    check("t4.held", bus.remain, 3);
    step(1'b1, 2'b10, 1'b1, 1'b0, "t4");
    check("t4.resume_motor", bus.motor, 1);
    run_until(3, 100, "t4");
    step(1'b0, 2'b01, 1'b1, 1'b0, "t4");
    idle(3, "t4");
    step(1'b0, 2'b01, 1'b0, 1'b1, "t4");
    check("t4.drain_phase", bus.phase, 5);
    check("t4.drain_remain", bus.remain, 2);
    check("t4.drain_paused", bus.paused, 0);
    check("t4.drain_pump", bus.drain, 1);
    check("t4.aborted", bus.aborted, 1);
    idle(8, "t4");
    check("t4.drain_done", bus.done, 1);
    idle(1, "t4");
    step(1'b1, 2'b01, 1'b0, 1'b0, "t4");
    check("t4.aborted_clear", bus.aborted, 0);

    // Pause arriving on the tick cycle drops that tick.
    r = 0;
    while (!(m_sub == TICK - 1 && m_phase >= 1 && m_phase <= 4 && !m_paused) && r < 50) begin idle(1, "t5"); r++; end
    r = m_remain;
    step(1'b0, 2'b01, 1'b1, 1'b0, "t5");
    check("t5.tick_dropped", bus.remain, r);
    check("t5.paused", bus.paused, 1);
    step(1'b0, 2'b01, 1'b1, 1'b0, "t5");
    step(1'b0, 2'b01, 1'b0, 1'b1, "t5");
    run_until(0, 40, "t5");

    // Reset in the middle of SPIN.
    step(1'b1, 2'b00, 1'b0, 1'b0, "t6");
    idle(5, "t6");
    apply_reset("t6.rst");
    check("t6.no_done", bus.done, 0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      bit s, p, a;
      s = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 30) == 0);
      p = ($urandom_range(0, 25) == 0);
      a = ($urandom_range(0, 120) == 0);
      step(s, 2'($urandom_range(0, 3)), p, a, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
